// File: rtl/stage_e_pkg.sv
// stage_e_pkg: shared encodings for the MIPS execute stage.
//   ALU operation codes, multiply/divide op codes, HI/LO read selects,
//   operand forwarding selects, MDU state type and a 32x32->64 multiply helper.
//   No ports (package).
package stage_e_pkg;

    // ALU operation encodings (ALUCtrlE)
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_SLLV = 4'd11;
    localparam logic [3:0] ALU_SRLV = 4'd12;
    localparam logic [3:0] ALU_SRAV = 4'd13;
    localparam logic [3:0] ALU_LUI  = 4'd14;
    localparam logic [3:0] ALU_ZERO = 4'd15;

    // Multiply/divide unit op encodings (MDOpE)
    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_MADD  = 3'd7;

    // Result select (MDReadE)
    localparam logic [1:0] MDR_ALU = 2'd0;
    localparam logic [1:0] MDR_HI  = 2'd1;
    localparam logic [1:0] MDR_LO  = 2'd2;

    // Operand forwarding selects (FwdAE / FwdBE)
    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_M    = 2'd1;
    localparam logic [1:0] FWD_W    = 2'd2;
    localparam logic [1:0] FWD_LINK = 2'd3;

    // Link value is the M-stage PC+4 plus one more instruction (PC+8)
    localparam logic [31:0] LINK_OFFSET = 32'd4;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    // Low 64 bits of a product of two 64-bit extended operands equal the
    // exact 32x32 product for both signed and unsigned interpretations.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_signed);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        bx = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        return ax * bx;
    endfunction

endpackage

// File: rtl/stage_e_mdu.sv
// mdu: multi-cycle multiply/divide unit with HI/LO registers.
//   Optional feature macro: STAGE_E_MADD_EN (op 7 = signed multiply-accumulate).
//   Ports: clk, reset (async active-high), valid (real instruction),
//          op (MD_* code), a (forwarded rs), b (forwarded rt),
//          hi/lo (architectural HI/LO), busy (BUSY or starting), start.
module mdu
    import stage_e_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        start
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_t        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       a_r;
    logic [31:0]       b_r;
    logic [2:0]        op_r;

    logic              is_mul_op_s;
    logic              is_div_op_s;
    logic [31:0]       res_hi_s;
    logic [31:0]       res_lo_s;
    logic signed [31:0] sa_s;
    logic signed [31:0] sb_s;
    logic signed [31:0] sq_s;
    logic signed [31:0] sr_s;

    // Decode which incoming ops launch a multi-cycle operation
    always_comb begin
        is_mul_op_s = 1'b0;
        is_div_op_s = 1'b0;
        case (op)
            MD_MULT, MD_MULTU: is_mul_op_s = 1'b1;
`ifdef STAGE_E_MADD_EN
            MD_MADD:           is_mul_op_s = 1'b1;
`endif
            MD_DIV, MD_DIVU:   is_div_op_s = 1'b1;
            default: begin
                is_mul_op_s = 1'b0;
                is_div_op_s = 1'b0;
            end
        endcase
    end

    // Reset gates start so busy drops the instant reset is asserted
    assign start = ~reset & valid & (is_mul_op_s | is_div_op_s) & (state_r == MDU_IDLE);
    assign busy  = (state_r == MDU_BUSY) | start;

    // SV signed divide truncates toward zero; remainder follows the dividend
    assign sa_s = $signed(a_r);
    assign sb_s = $signed(b_r);
    assign sq_s = sa_s / sb_s;
    assign sr_s = sa_s % sb_s;

    // HI/LO values to commit at completion, from the latched operands
    always_comb begin
        res_hi_s = hi;
        res_lo_s = lo;
        case (op_r)
            MD_MULT:  {res_hi_s, res_lo_s} = mul64(a_r, b_r, 1'b1);
            MD_MULTU: {res_hi_s, res_lo_s} = mul64(a_r, b_r, 1'b0);
`ifdef STAGE_E_MADD_EN
            MD_MADD:  {res_hi_s, res_lo_s} = {hi, lo} + mul64(a_r, b_r, 1'b1);
`endif
            MD_DIV: begin
                if (b_r != 32'd0) begin
                    res_lo_s = sq_s;
                    res_hi_s = sr_s;
                end else begin
                    res_lo_s = lo;
                    res_hi_s = hi;
                end
            end
            MD_DIVU: begin
                if (b_r != 32'd0) begin
                    res_lo_s = a_r / b_r;
                    res_hi_s = a_r % b_r;
                end else begin
                    res_lo_s = lo;
                    res_hi_s = hi;
                end
            end
            default: begin
                res_hi_s = hi;
                res_lo_s = lo;
            end
        endcase
    end

    // MDU FSM, countdown and HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= MDU_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            op_r    <= MD_NONE;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            case (state_r)
                MDU_IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        op_r    <= op;
                        cnt_r   <= is_div_op_s ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_r <= MDU_BUSY;
                    end else if (valid && op == MD_MTHI) begin
                        hi <= a;
                    end else if (valid && op == MD_MTLO) begin
                        lo <= a;
                    end
                end
                MDU_BUSY: begin
                    if (cnt_r == CNT_W'(1)) begin
                        hi      <= res_hi_s;
                        lo      <= res_lo_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= MDU_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: state_r <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/stage_e.sv
// stage_e: execute stage of the 5-stage MIPS pipeline.
//   Optional feature macro: STAGE_E_MADD_EN (enables madd in the MDU).
//   Ports: clk, reset (async active-high), ValidE, RD1E/RD2E (register file),
//          ExtImmE, ShamtE, ALUCtrlE, ALUSrcE, FwdAE/FwdBE (forwarding selects),
//          ResM/ResW/PC4M (forwarding sources), MDOpE, MDReadE;
//          outputs ResE (E/M result), MemWDE (store data), BusyE, HI, LO.
//   Datapath outputs are combinational; the E/M register lives outside.
module stage_e
    import stage_e_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ValidE,
    input  logic [31:0] RD1E,
    input  logic [31:0] RD2E,
    input  logic [31:0] ExtImmE,
    input  logic [4:0]  ShamtE,
    input  logic [3:0]  ALUCtrlE,
    input  logic        ALUSrcE,
    input  logic [1:0]  FwdAE,
    input  logic [1:0]  FwdBE,
    input  logic [31:0] ResM,
    input  logic [31:0] ResW,
    input  logic [31:0] PC4M,
    input  logic [2:0]  MDOpE,
    input  logic [1:0]  MDReadE,
    output logic [31:0] ResE,
    output logic [31:0] MemWDE,
    output logic        BusyE,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic [31:0] a_s;
    logic [31:0] rt_s;
    logic [31:0] b_s;
    logic [31:0] alu_s;
    logic [31:0] link_s;
    logic        md_start_s;

    assign link_s = PC4M + LINK_OFFSET;

    // rs operand forwarding
    always_comb begin
        case (FwdAE)
            FWD_RF:   a_s = RD1E;
            FWD_M:    a_s = ResM;
            FWD_W:    a_s = ResW;
            FWD_LINK: a_s = link_s;
            default:  a_s = RD1E;
        endcase
    end

    // rt operand forwarding (also the store data)
    always_comb begin
        case (FwdBE)
            FWD_RF:   rt_s = RD2E;
            FWD_M:    rt_s = ResM;
            FWD_W:    rt_s = ResW;
            FWD_LINK: rt_s = link_s;
            default:  rt_s = RD2E;
        endcase
    end

    assign b_s    = ALUSrcE ? ExtImmE : rt_s;
    assign MemWDE = rt_s;

    // ALU; shifts always operate on B
    always_comb begin
        case (ALUCtrlE)
            ALU_ADD:  alu_s = a_s + b_s;
            ALU_SUB:  alu_s = a_s - b_s;
            ALU_AND:  alu_s = a_s & b_s;
            ALU_OR:   alu_s = a_s | b_s;
            ALU_XOR:  alu_s = a_s ^ b_s;
            ALU_NOR:  alu_s = ~(a_s | b_s);
            ALU_SLT:  alu_s = {31'd0, ($signed(a_s) < $signed(b_s))};
            ALU_SLTU: alu_s = {31'd0, (a_s < b_s)};
            ALU_SLL:  alu_s = b_s << ShamtE;
            ALU_SRL:  alu_s = b_s >> ShamtE;
            ALU_SRA:  alu_s = $unsigned($signed(b_s) >>> ShamtE);
            ALU_SLLV: alu_s = b_s << a_s[4:0];
            ALU_SRLV: alu_s = b_s >> a_s[4:0];
            ALU_SRAV: alu_s = $unsigned($signed(b_s) >>> a_s[4:0]);
            ALU_LUI:  alu_s = b_s << 5'd16;
            ALU_ZERO: alu_s = 32'd0;
            default:  alu_s = 32'd0;
        endcase
    end

    // Result select: mfhi/mflo override the ALU result
    always_comb begin
        case (MDReadE)
            MDR_HI:  ResE = HI;
            MDR_LO:  ResE = LO;
            default: ResE = alu_s;
        endcase
    end

    mdu #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu (
        .clk   (clk),
        .reset (reset),
        .valid (ValidE),
        .op    (MDOpE),
        .a     (a_s),
        .b     (rt_s),
        .hi    (HI),
        .lo    (LO),
        .busy  (BusyE),
        .start (md_start_s)
    );

endmodule

// File: doc/stage_e.md
Name: stage_e

Overview:
- Execute stage of the 5-stage MIPS pipeline; sits directly upstream of the memory stage.
- Forwards rs/rt operands, computes the ALU result and drives it as the memory address/result into the E/M register.
- Forwards store data and contains a multi-cycle multiply/divide unit (MDU) with HI/LO registers.
- Exports a busy signal that the hazard unit uses to stall mult/div/mfhi/mflo/mthi/mtlo.

Parameters:
- MULT_CYCLES, 5, cycles busy after a mult/multu start edge
- DIV_CYCLES, 10, cycles busy after a div/divu start edge

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all MDU state
- ValidE  in  1  E-stage holds a real instruction (0 = bubble)
- RD1E  in  32  rs value from register file
- RD2E  in  32  rt value from register file
- ExtImmE  in  32  extended immediate
- ShamtE  in  5  instr[10:6]
- ALUCtrlE  in  4  ALU op (see Behaviour)
- ALUSrcE  in  1  0: B = fwd rt; 1: B = ExtImmE
- FwdAE  in  2  rs source: 0 RD1E, 1 ResM, 2 ResW, 3 PC4M+4
- FwdBE  in  2  rt source: same encoding as FwdAE
- ResM  in  32  M-stage result
- ResW  in  32  W-stage result
- PC4M  in  32  M-stage PC+4
- MDOpE  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd
- MDReadE  in  2  0 ALU, 1 mfhi, 2 mflo
- ResE  out  32  result to E/M register
- MemWDE  out  32  forwarded rt, store data
- BusyE  out  1  MDU busy, or a mult/div starting this cycle
- HI  out  32  HI register
- LO  out  32  LO register

Behaviour:
- Operands: A = FwdAE mux, fwd-rt = FwdBE mux (3 = PC4M+4, link value), B = ALUSrcE ? ExtImmE : fwd-rt.
- MemWDE = fwd-rt. All datapath outputs are combinational; the E/M register is external.
- ALUCtrlE encodings:
  - 0 A+B, wrapping; 1 A-B, wrapping
  - 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT signed, 7 SLTU → 32'd1 or 32'd0
  - 8 SLL, 9 SRL, 10 SRA: B shifted by ShamtE
  - 11 SLLV, 12 SRLV, 13 SRAV: B shifted by A[4:0]
  - 14 LUI: B<<16
  - 15 → 32'h0
- ResE = MDReadE==1 ? HI : MDReadE==2 ? LO : ALU; MDReadE==3 → ALU.
- MDU states: IDLE, BUSY. The start condition below is sampled at the rising edge.
  - start = ValidE & MDOpE∈{1,2,3,4,(7)} & IDLE.
  - On start: latch A and fwd-rt and the op; load cnt = MULT_CYCLES (ops 1,2,7) or DIV_CYCLES (ops 3,4); enter BUSY.
  - In BUSY: cnt decrements each edge. At the edge where cnt==1, write HI/LO from the latched operands and return to IDLE.
  - BUSY therefore lasts exactly N cycles; new HI/LO are visible the cycle after busy drops.
- MDU arithmetic:
  - mult: signed 64-bit product {HI,LO}.
  - multu: unsigned 64-bit product {HI,LO}.
  - div/divu: LO = quotient, HI = remainder; signed divide truncates toward zero and the remainder takes the dividend's sign.
  - Divisor 0: HI/LO unchanged, busy still DIV_CYCLES.
- mthi/mtlo: when ValidE & IDLE, HI or LO ← A at the edge, single cycle, BusyE not raised.
- BusyE = BUSY | start-condition (combinational).
- Start or mthi/mtlo while BUSY is ignored. The hazard unit guarantees this never happens; the bench asserts it.
- ValidE=0: no MDU state change.
- Reset, including mid-operation: HI=0, LO=0, cnt=0, state IDLE, BusyE=0 immediately (async). Any in-flight result is discarded.

Optional Feature:
- Macro: STAGE_E_MADD_EN.
- Defined: MDOpE=7 (madd) starts a MULT_CYCLES operation; at completion {HI,LO} ← {HI,LO} + signed(A×B), wrapping at 64 bits, using HI/LO as they are at completion.
- Undefined: MDOpE=7 behaves as 0 (no start, BusyE unaffected).

Decomposition:
- Package stage_e_pkg:
  - ALU op localparams (ALU_ADD..ALU_LUI)
  - MDOp codes (MD_NONE..MD_MADD)
  - MDRead codes
  - Fwd select codes (FWD_RF, FWD_M, FWD_W, FWD_LINK)
- Sub-module mdu: holds the counter, FSM and HI/LO; receives op, A, B, ValidE; outputs HI, LO, busy, start.
- stage_e itself contains the forwarding muxes, ALU and result mux.

Test Plan:
- FwdAE=3, PC4M=32'h3004, ALUCtrlE=0, ALUSrcE=1, ExtImmE=0 → ResE=32'h3008; FwdBE=1, ResM=32'h55 → MemWDE=32'h55.
- mult with A=32'hFFFFFFFF, B=2 → BusyE=1 for 5 cycles after the start edge plus the start cycle; then HI=32'hFFFFFFFF, LO=32'hFFFFFFFE. Same operands with multu → HI=1, LO=32'hFFFFFFFE.
- div with A=-7, B=2 → after 10 cycles LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; mflo gives ResE=32'hFFFFFFFD.
- mthi 32'h12 → HI=32'h12, BusyE=0; then div by 0 → after 10 busy cycles HI=32'h12 and LO unchanged.
- reset asserted at cycle 4 of a div → BusyE=0, HI=LO=0 asynchronously; the next mult starts normally.
- With STAGE_E_MADD_EN: HI=0, LO=32'hFFFFFFFF, madd 1×1 → HI=1, LO=0. Without the macro, op 7 → BusyE=0 and HI/LO unchanged.
